// File: rtl/ipsum_fetch_if.sv
// ipsum_fetch_if: handshake and SRAM bundle for ipsum_fetch.
//   Request side : start, base_addr, layer_type, first_pass, busy
//   SRAM side    : sram_re, sram_addr, sram_rdata (data one cycle after re)
//   Reducer side : ipsum_out, ipsum_add_en, ipsum_valid, ipsum_ready
// The slave modport is the fetch unit itself; master is whatever drives it
// (controller, SRAM and reducer together, or a testbench).
interface ipsum_fetch_if #(
   parameter int LANES  = 32,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic                          start;
   logic [ADDR_W-1:0]             base_addr;
   logic [1:0]                    layer_type;
   logic                          first_pass;
   logic                          busy;
   logic                          sram_re;
   logic [ADDR_W-1:0]             sram_addr;
   logic [2*DATA_W-1:0]           sram_rdata;
   logic [LANES-1:0][DATA_W-1:0]  ipsum_out;
   logic                          ipsum_add_en;
   logic                          ipsum_valid;
   logic                          ipsum_ready;

   modport master (
      output start, base_addr, layer_type, first_pass, sram_rdata, ipsum_ready,
      input  busy, sram_re, sram_addr, ipsum_out, ipsum_add_en, ipsum_valid
   );

   modport slave (
      input  start, base_addr, layer_type, first_pass, sram_rdata, ipsum_ready,
      output busy, sram_re, sram_addr, ipsum_out, ipsum_add_en, ipsum_valid
   );
endinterface

// File: rtl/ipsum_fetch.sv
// ipsum_fetch: reads the previous pass's 16-bit partial sums from the psum
// SRAM (two lanes per 32-bit word), unpacks them into a LANES-wide vector and
// offers it to the reducer under valid/ready. On a first input-channel pass
// no reads are made and a zero vector is offered with ipsum_add_en=0.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       ipsum_fetch_if.slave (start/base_addr/layer_type/first_pass in,
//             busy out; sram_re/sram_addr out, sram_rdata in;
//             ipsum_out/ipsum_add_en/ipsum_valid out, ipsum_ready in)
`ifndef POINTWISE
`define POINTWISE 2'd0
`endif

module ipsum_fetch #(
   parameter int LANES    = 32,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int DW_LANES = 10
) (
   input  logic          clk,
   input  logic          rst,
   ipsum_fetch_if.slave  bus
);
   localparam int WORDS    = LANES / 2;
   localparam int DW_WORDS = DW_LANES / 2;
   localparam int CNT_W    = $clog2(WORDS + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]          state_reg;
   logic [ADDR_W-1:0]   base_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [CNT_W-1:0]    n_reg;
   logic [CNT_W-1:0]    k_reg;        // index of the next read to issue
   logic [CNT_W-1:0]    cap_idx_reg;  // word slot for the next returning word
   logic                cap_en_reg;   // sram_re delayed one cycle: rdata valid now
   logic                add_en_reg;
   logic                busy_reg;
   logic                re_reg;
   logic                valid_reg;
   logic                start_accept;
   logic [2*DATA_W-1:0] word_reg [WORDS];

   // Starts are only honoured in IDLE, so a start on the handshake cycle is dropped.
   assign start_accept = (state_reg == IDLE) && bus.start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         base_reg    <= '0;
         addr_reg    <= '0;
         n_reg       <= '0;
         k_reg       <= '0;
         cap_idx_reg <= '0;
         cap_en_reg  <= 1'b0;
         add_en_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         re_reg      <= 1'b0;
         valid_reg   <= 1'b0;
      end else begin
         cap_en_reg <= re_reg;
         if (start_accept)
            cap_idx_reg <= '0;
         else if (cap_en_reg)
            cap_idx_reg <= cap_idx_reg + 1'b1;

         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  base_reg   <= bus.base_addr;
                  n_reg      <= (bus.layer_type == `POINTWISE) ? CNT_W'(WORDS)
                                                               : CNT_W'(DW_WORDS);
                  add_en_reg <= ~bus.first_pass;
                  busy_reg   <= 1'b1;
                  if (bus.first_pass) begin
                     state_reg <= HOLD;
                     valid_reg <= 1'b1;
                  end else begin
                     // Read 0 goes out in the very next cycle.
                     state_reg <= REQ;
                     re_reg    <= 1'b1;
                     addr_reg  <= bus.base_addr;
                     k_reg     <= CNT_W'(1);
                  end
               end
            end
            REQ: begin
               if (k_reg == n_reg) begin
                  re_reg    <= 1'b0;
                  state_reg <= DRAIN;
               end else begin
                  addr_reg <= base_reg + ADDR_W'(k_reg);  // modular wrap
                  k_reg    <= k_reg + 1'b1;
               end
            end
            DRAIN: begin
               // Last word is captured on this edge, so the vector is complete.
               state_reg <= HOLD;
               valid_reg <= 1'b1;
            end
            HOLD: begin
               if (bus.ipsum_ready) begin
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
                  busy_reg  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // One register per SRAM word; each word holds lanes 2*gi (low) and 2*gi+1 (high).
   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               word_reg[gi] <= '0;
            else if (start_accept)
               word_reg[gi] <= '0;
            else if (cap_en_reg && (cap_idx_reg == CNT_W'(gi)))
               word_reg[gi] <= bus.sram_rdata;
         end
         assign bus.ipsum_out[2*gi]   = word_reg[gi][DATA_W-1:0];
         assign bus.ipsum_out[2*gi+1] = word_reg[gi][2*DATA_W-1:DATA_W];
      end
   endgenerate

   assign bus.busy         = busy_reg;
   assign bus.sram_re      = re_reg;
   assign bus.sram_addr    = addr_reg;
   assign bus.ipsum_add_en = add_en_reg;
   assign bus.ipsum_valid  = valid_reg;
endmodule
